// File: rtl/uart_cmd_ctrl.sv
// UART command/response controller: decodes single-byte commands, drives the Sobel enable,
// counts camera frames and returns 5-byte framed responses. Optional macro: UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic        SOBEL_EN_RST = 1'b0,
  parameter logic [31:0] TX_TIMEOUT   = 32'd2700000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       frame_sync,
  output logic       sobel_enable,
  output logic       busy,
  output logic       err_sticky
);

  localparam logic [7:0] HDR_BYTE      = 8'hA5;
  localparam logic [7:0] ERR_CMD       = 8'h15;
  localparam logic [7:0] CMD_SOBEL_ON  = 8'h53;
  localparam logic [7:0] CMD_SOBEL_OFF = 8'h73;
  localparam logic [7:0] CMD_READ_CNT  = 8'h52;
  localparam logic [7:0] CMD_DIAG      = 8'h44;

  typedef enum logic [2:0] {IDLE, HDR, CMD, PH, PL, CSUM} state_t;

  state_t                 state;
  logic [7:0]             cmd_q;
  logic [7:0]             ph_q;
  logic [7:0]             pl_q;
  logic [7:0]             last_cmd;
  logic [15:0]            frame_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   frame_edge;
  logic                   tx_abort;

  assign frame_edge = sync_q[SYNC_STAGES-1] & ~sync_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      frame_cnt <= 16'h0000;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], frame_sync};
      sync_prev <= sync_q[SYNC_STAGES-1];
      if (frame_edge) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  logic [31:0] wait_cnt;

  assign tx_abort = tx_valid && !tx_ready && (wait_cnt == TX_TIMEOUT - 32'd1);

  // Idle covers the reset-on-entry-to-HDR case; any accepted byte restarts the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 32'd0;
    end else if (state == IDLE || (tx_valid && tx_ready)) begin
      wait_cnt <= 32'd0;
    end else if (tx_valid) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout;

  assign tx_abort       = 1'b0;
  assign unused_timeout = ^TX_TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd_q        <= 8'h00;
      ph_q         <= 8'h00;
      pl_q         <= 8'h00;
      last_cmd     <= 8'h00;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      err_sticky   <= 1'b0;
      sobel_enable <= SOBEL_EN_RST;
    end else begin
      // A byte arriving mid-packet is dropped but remembered as an error.
      if (rx_valid && state != IDLE) err_sticky <= 1'b1;

      if (tx_abort) begin
        state      <= IDLE;
        busy       <= 1'b0;
        tx_valid   <= 1'b0;
        err_sticky <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid) begin
              last_cmd <= rx_data;
              cmd_q    <= rx_data;
              ph_q     <= 8'h00;
              pl_q     <= 8'h00;
              state    <= HDR;
              busy     <= 1'b1;
              tx_valid <= 1'b1;
              tx_data  <= HDR_BYTE;
              case (rx_data)
                CMD_SOBEL_ON: begin
                  sobel_enable <= 1'b1;
                  pl_q         <= 8'h01;
                end
                CMD_SOBEL_OFF: sobel_enable <= 1'b0;
                CMD_READ_CNT:  {ph_q, pl_q} <= frame_cnt;
                CMD_DIAG: begin
                  ph_q       <= {5'b0, err_sticky, 1'b0, sobel_enable};
                  pl_q       <= last_cmd;
                  err_sticky <= 1'b0;
                end
                default: begin
                  cmd_q      <= ERR_CMD;
                  pl_q       <= rx_data;
                  err_sticky <= 1'b1;
                end
              endcase
            end
          end
          HDR: if (tx_ready) begin
            state   <= CMD;
            tx_data <= cmd_q;
          end
          CMD: if (tx_ready) begin
            state   <= PH;
            tx_data <= ph_q;
          end
          PH: if (tx_ready) begin
            state   <= PL;
            tx_data <= pl_q;
          end
          PL: if (tx_ready) begin
            state   <= CSUM;
            tx_data <= cmd_q ^ ph_q ^ pl_q;
          end
          CSUM: if (tx_ready) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
